// File: rtl/decoder_nsel_seq.sv
// Registered one-hot select decoder with hold, timed pulse and free-running scan behaviours.
// A valid/ready handshake loads the select; mode=1 overrides it with a rotating scan.
module decoder_nsel_seq #(
  parameter int SEL_W      = 2,
  parameter int OUT_W      = 4,
  parameter int PULSE_LEN  = 0,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             y_valid,
  output logic             oor
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'((PULSE_LEN > 0) ? PULSE_LEN - 1 : 0);
  localparam logic [DW-1:0]    D_LAST = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] I_LAST = SEL_W'(OUT_W - 1);
  localparam logic [SEL_W:0]   N_OUT  = (SEL_W + 1)'(OUT_W);

  typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;

  state_t           state_reg;
  logic [OUT_W-1:0] y_reg;
  logic [SEL_W-1:0] idx_reg;
  logic             y_valid_reg;
  logic             oor_reg;
  logic [PW-1:0]    pcnt_reg;
  logic [DW-1:0]    dcnt_reg;

  logic             accept;
  logic             in_range;
  logic [SEL_W-1:0] idx_inc;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int k = 0; k < OUT_W; k++) v[k] = (i == SEL_W'(k));
    return v;
  endfunction

  assign sel_ready = ~rst & en & ~mode & (state_reg != PULSE);
  assign accept    = sel_valid & sel_ready;
  assign in_range  = ({1'b0, sel} < N_OUT);
  assign idx_inc   = (idx_reg == I_LAST) ? '0 : idx_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      y_reg       <= '0;
      idx_reg     <= '0;
      y_valid_reg <= 1'b0;
      oor_reg     <= 1'b0;
      pcnt_reg    <= '0;
      dcnt_reg    <= '0;
    end else if (!en) begin
      oor_reg <= 1'b0;
    end else if (mode) begin
      // Scan takes over from any direct state, aborting a pulse in flight.
      oor_reg     <= 1'b0;
      pcnt_reg    <= '0;
      y_valid_reg <= 1'b1;
      if (state_reg != SCAN) begin
        state_reg <= SCAN;
        idx_reg   <= '0;
        y_reg     <= onehot('0);
        dcnt_reg  <= '0;
      end else if (dcnt_reg == D_LAST) begin
        dcnt_reg <= '0;
        idx_reg  <= idx_inc;
        y_reg    <= onehot(idx_inc);
      end else begin
        dcnt_reg <= dcnt_reg + 1'b1;
      end
    end else if (accept) begin
      dcnt_reg <= '0;
      pcnt_reg <= '0;
      if (in_range) begin
        state_reg   <= (PULSE_LEN == 0) ? HOLD : PULSE;
        y_reg       <= onehot(sel);
        idx_reg     <= sel;
        y_valid_reg <= 1'b1;
        oor_reg     <= 1'b0;
      end else begin
        state_reg   <= IDLE;
        y_reg       <= '0;
        idx_reg     <= '0;
        y_valid_reg <= 1'b0;
        oor_reg     <= 1'b1;
      end
    end else begin
      oor_reg <= 1'b0;
      if (state_reg == SCAN) begin
        state_reg   <= IDLE;
        y_reg       <= '0;
        idx_reg     <= '0;
        y_valid_reg <= 1'b0;
        dcnt_reg    <= '0;
      end else if (state_reg == PULSE) begin
        if (pcnt_reg == P_LAST) begin
          state_reg   <= IDLE;
          y_reg       <= '0;
          idx_reg     <= '0;
          y_valid_reg <= 1'b0;
          pcnt_reg    <= '0;
        end else begin
          pcnt_reg <= pcnt_reg + 1'b1;
        end
      end
    end
  end

  // Polarity applies to y only; idx, y_valid and oor stay active-high.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pol
    assign y[gi] = (ACTIVE_LOW != 0) ? ~y_reg[gi] : y_reg[gi];
  end

  assign idx     = idx_reg;
  assign y_valid = y_valid_reg;
  assign oor     = oor_reg;

endmodule

// File: tb/tb_decoder_nsel_seq.sv
// Bench for decoder_nsel_seq: two builds (hold/scan and pulse/active-low/out-of-range)
// share one stimulus stream and are checked each cycle against a behavioural model.
module tb_decoder_nsel_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, sel_valid;
  logic [1:0] sel;
  logic       r0, r1, v0, v1, o0, o1;
  logic [3:0] y0;
  logic [2:0] y1;
  logic [1:0] i0, i1;

  int checks = 0;
  int errors = 0;

  decoder_nsel_seq #(.SEL_W(2), .OUT_W(4), .PULSE_LEN(0), .DWELL(2), .ACTIVE_LOW(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(r0), .y(y0), .idx(i0), .y_valid(v0), .oor(o0));

  decoder_nsel_seq #(.SEL_W(2), .OUT_W(3), .PULSE_LEN(3), .DWELL(3), .ACTIVE_LOW(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(r1), .y(y1), .idx(i1), .y_valid(v1), .oor(o1));

  // act: driven output index (-1 none); rem: pulse cycles left; t: cycles since scan start
  typedef struct {
    int act;
    int rem;
    bit scanning;
    int t;
    bit oor;
  } mst_t;

  mst_t m0, m1;
  bit   started = 1'b0;

  function automatic mst_t step(mst_t s, int ow, int pl, int dw);
    mst_t n;
    n = s;
    if (rst) begin
      n.act = -1; n.rem = 0; n.scanning = 1'b0; n.t = 0; n.oor = 1'b0;
      return n;
    end
    n.oor = 1'b0;
    if (!en) return n;
    if (mode) begin
      n.t        = s.scanning ? (s.t + 1) % (ow * dw) : 0;
      n.scanning = 1'b1;
      n.rem      = 0;
      n.act      = n.t / dw;
      return n;
    end
    if (sel_valid && !(s.rem > 0 && !s.scanning)) begin
      n.scanning = 1'b0;
      n.t        = 0;
      if (int'(sel) < ow) begin
        n.act = int'(sel);
        n.rem = pl;
      end else begin
        n.act = -1;
        n.rem = 0;
        n.oor = 1'b1;
      end
    end else if (s.scanning) begin
      n.scanning = 1'b0;
      n.t        = 0;
      n.act      = -1;
    end else if (s.rem > 0) begin
      n.rem = s.rem - 1;
      if (n.rem == 0) n.act = -1;
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_y(mst_t s, int ow, bit al);
    logic [31:0] v;
    v = (s.act >= 0) ? (32'd1 << s.act) : 32'd0;
    if (al) v = ~v & ((32'd1 << ow) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] exp_ready(mst_t s);
    return {31'd0, (!rst && en && !mode && !(s.rem > 0 && !s.scanning))};
  endfunction

  function automatic logic [31:0] exp_idx(mst_t s);
    return (s.act >= 0) ? 32'(s.act) : 32'd0;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m0 = step(m0, 4, 0, 2);
    m1 = step(m1, 3, 3, 3);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      cmp("u0.y", 32'(y0), exp_y(m0, 4, 1'b0));
      cmp("u0.idx", 32'(i0), exp_idx(m0));
      cmp("u0.y_valid", 32'(v0), {31'd0, m0.act >= 0});
      cmp("u0.oor", 32'(o0), {31'd0, m0.oor});
      cmp("u0.sel_ready", 32'(r0), exp_ready(m0));
      cmp("u1.y", 32'(y1), exp_y(m1, 3, 1'b1));
      cmp("u1.idx", 32'(i1), exp_idx(m1));
      cmp("u1.y_valid", 32'(v1), {31'd0, m1.act >= 0});
      cmp("u1.oor", 32'(o1), {31'd0, m1.oor});
      cmp("u1.sel_ready", 32'(r1), exp_ready(m1));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] scan_exp [9];

  initial begin
    scan_exp = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1};
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel_valid = 1'b0; sel = 2'd0;
    cyc(); cyc();
    @(negedge clk);
    cmp("lit.rst_ready", 32'(r0), 32'd0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    cmp("lit.reset_y0", 32'(y0), 32'h0);
    cmp("lit.reset_ready", 32'(r0), 32'd1);
    cmp("lit.reset_y1_al", 32'(y1), 32'h7);

    // Accept sel=2 on both, then sel=3 held across u1's pulse.
    cyc(); sel_valid = 1'b1; sel = 2'd2;
    cyc(); sel = 2'd3;
    @(negedge clk);
    cmp("lit.hold_y0", 32'(y0), 32'h4);
    cmp("lit.hold_idx0", 32'(i0), 32'd2);
    cmp("lit.pulse_y1_al", 32'(y1), 32'h3);
    cmp("lit.pulse_ready1", 32'(r1), 32'd0);
    cyc();
    @(negedge clk);
    cmp("lit.nogap_y0", 32'(y0), 32'h8);
    cmp("lit.pulse_y1_c2", 32'(y1), 32'h3);
    cyc(); cyc();
    @(negedge clk);
    cmp("lit.pulse_end_y1", 32'(y1), 32'h7);
    cmp("lit.pulse_end_v1", 32'(v1), 32'd0);
    cmp("lit.pulse_end_ready1", 32'(r1), 32'd1);
    cyc(); sel_valid = 1'b0;
    @(negedge clk);
    cmp("lit.oor_pulse", 32'(o1), 32'd1);
    cyc();
    @(negedge clk);
    cmp("lit.oor_clear", 32'(o1), 32'd0);

    // Scan with DWELL=2 on u0, freeze, then leave scan.
    cyc(); mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); @(negedge clk);
      cmp("lit.scan_y0", 32'(y0), 32'(scan_exp[i]));
    end
    cyc(); en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      cmp("lit.freeze_y0", 32'(y0), 32'h1);
      cmp("lit.freeze_idx0", 32'(i0), 32'd0);
    end
    cyc(); en = 1'b1;
    @(posedge clk); @(negedge clk);
    cmp("lit.resume_y0", 32'(y0), 32'h2);
    cyc(); mode = 1'b0;
    @(posedge clk); @(negedge clk);
    cmp("lit.scan_exit_y0", 32'(y0), 32'h0);

    // Reset in the middle of a pulse.
    cyc(); sel_valid = 1'b1; sel = 2'd1;
    cyc(); sel_valid = 1'b0;
    @(negedge clk);
    cmp("lit.pulse1_y1_al", 32'(y1), 32'h5);
    cyc(); rst = 1'b1;
    @(posedge clk); @(negedge clk);
    cmp("lit.rst_pulse_y1", 32'(y1), 32'h7);
    cmp("lit.rst_pulse_v1", 32'(v1), 32'd0);
    cmp("lit.rst_y0", 32'(y0), 32'h0);
    cyc(); rst = 1'b0;

    repeat (3000) begin
      cyc();
      rst       = ($urandom % 60 == 0);
      en        = ($urandom % 8 != 0);
      if ($urandom % 16 == 0) mode = ~mode;
      sel_valid = $urandom % 2 == 0;
      sel       = 2'($urandom % 4);
    end
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
